stack_unit: RTL and testbench
=============================

# stack_unit

LIFO operand stack for the multicycle stack processor; it responds to the `push`, `pop` and `tos` strobes that the processor controller issues. It holds up to DEPTH words and presents the word read out on a registered output that the datapath captures one cycle later (A register, memory write data). It also reports occupancy and sticky overflow/underflow errors.

## Interface
- `WIDTH`, default 8: data word width.
- `DEPTH`, default 16: maximum number of entries; must be a power of two and at least 2.
- `CW`, default `$clog2(DEPTH+1)`: width of `count`; derived, not overridden.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `push`  in  1  push `din` this cycle.
- `pop`  in  1  remove the top entry and return it on `dout`.
- `tos`  in  1  return the top entry on `dout` without removing it.
- `din`  in  WIDTH  data to push (ALU result or memory data, muxed upstream).
- `clr_err`  in  1  clears the sticky error flags.
- `dout`  out  WIDTH  registered read data.
- `dout_vld`  out  1  one-cycle pulse: `dout` was updated by the previous edge.
- `count`  out  CW  current number of entries.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `ovf`  out  1  sticky: push was attempted while full.
- `udf`  out  1  sticky: pop or tos was attempted while empty.

## Operation
- State: storage array `mem[DEPTH]`, pointer `sp` (= `count`, next free slot), `dout` register, and the error flags.
- Decode per cycle, evaluated on the pre-edge `count`:
  - push only, not full: `mem[sp] <= din`, `sp <= sp+1`.
  - push only, full: no change to memory or `sp`; `ovf <= 1`.
  - pop, not empty: `dout <= mem[sp-1]`, `sp <= sp-1`, `dout_vld <= 1`.
  - pop, empty: `sp` and `dout` hold; `udf <= 1`; `dout_vld <= 0`.
  - tos only, not empty: `dout <= mem[sp-1]`, `dout_vld <= 1`, `sp` unchanged.
  - tos only, empty: `dout` holds; `udf <= 1`.
  - push and pop, not empty (replace top): `dout <= mem[sp-1]`, `mem[sp-1] <= din`, `sp` unchanged. This is legal when full.
  - push and pop, empty: treated as a push of `din`; `udf <= 1`.
  - `tos` together with `pop`: `tos` is ignored and `pop` governs.
- `clr_err`: `ovf` and `udf` go to 0. If an error event occurs in the same cycle, set wins.
- Memory contents are not reset. Reads of entries at or above `sp` are never made.
- `count` never exceeds `DEPTH` and never underflows; `sp` does not wrap.

## Timing
- Reset (asynchronous on `rst_n` low): `sp=0`, `dout=0`, `dout_vld=0`, `ovf=0`, `udf=0`. Therefore `empty=1` and `full=0`.
- Reset may occur mid-sequence. Stack contents are logically discarded and the first push after release goes to slot 0.
- Read latency is 1 cycle. `dout` is valid in the cycle after the `pop`/`tos` strobe, which matches the controller capturing `Awrite`/`memTostack` one state later.
- Back-to-back pops on consecutive cycles return successive entries: each pop sees the `sp` updated by the previous edge.
- A push followed by a `tos` on the next cycle returns the pushed value; no bypass is needed within a cycle.
- `count`, `empty` and `full` are combinational from `sp`. They reflect the post-edge state immediately.
- `dout` holds its value on every cycle without a successful read.

## Structure
- `stack_pkg` holds `STACK_WIDTH` and `STACK_DEPTH` defaults shared with the processor datapath, plus the `stack_op_t` encoding (`NOP`, `PUSH`, `POP`, `TOS`, `REPL`) used by the decode and by bench scoreboards.
- Sub-module `stack_mem`: DEPTH×WIDTH register array with one synchronous write port and one combinational read port, no reset.
- `stack_unit` contains the pointer, decode, error flags and `dout` register.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on three cycles, then `tos` → next cycle `dout=0x33`, `dout_vld=1`, `count=3`.
- Pop three times back-to-back → `dout` = 0x33, 0x22, 0x11 on consecutive cycles; `empty=1` afterwards; `udf=0`.
- Fill with DEPTH pushes, then one more push of 0xAA → `full=1`, `count` stays at DEPTH, `ovf=1`. Pop → returns the last legal value, not 0xAA.
- On empty, pop, then assert `clr_err` → `udf=1` and `dout` unchanged; after `clr_err`, `udf=0`.
- With stack contents 0x05, 0x07, assert push(0x09) and pop together → `dout=0x07`, `count=2`; a following `tos` gives 0x09.
- Drop `rst_n` asynchronously between clock edges while `count=4` → all outputs reach their reset values immediately; after release, push 0x42 then `tos` → `dout=0x42`, `count=1`.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared stack parameters and operation encoding for the stack processor datapath.
// Used by stack_unit decode and by bench scoreboards.
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [2:0] {
        NOP,
        PUSH,
        POP,
        TOS,
        REPL
    } stack_op_t;

    // pop governs over tos; push with tos (no pop) is a plain push
    function automatic stack_op_t stack_decode(input logic push, input logic pop, input logic tos);
        stack_op_t op;
        op = NOP;
        if (pop && push)  op = REPL;
        else if (pop)     op = POP;
        else if (push)    op = PUSH;
        else if (tos)     op = TOS;
        return op;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH registers, one synchronous write port, one combinational read.
// Write takes effect at the edge; read is same-cycle; no backpressure, contents not reset.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack with pointer, decode, sticky overflow/underflow flags and registered read data.
// dout valid one cycle after pop/tos; no backpressure, illegal ops are dropped and flagged.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] mem_rdata;
    stack_op_t        op;

    // low bits wrap to DEPTH-1 when sp == DEPTH, which is exactly the top slot
    assign top_idx = sp_q[AW-1:0] - AW'(1);
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == CW'(DEPTH));

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (din),
        .raddr_i (top_idx),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        op         = stack_decode(push, pop, tos);
        sp_d       = sp_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        ovf_d      = ovf_q & ~clr_err;
        udf_d      = udf_q & ~clr_err;
        mem_we     = 1'b0;
        mem_waddr  = sp_q[AW-1:0];

        case (op)
            PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + CW'(1);
                end
            end
            POP: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    dout_d     = mem_rdata;
                    dout_vld_d = 1'b1;
                    sp_d       = sp_q - CW'(1);
                end
            end
            TOS: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    dout_d     = mem_rdata;
                    dout_vld_d = 1'b1;
                end
            end
            REPL: begin
                mem_we = 1'b1;
                if (empty) begin
                    // degrades to a push into slot 0
                    udf_d = 1'b1;
                    sp_d  = sp_q + CW'(1);
                end else begin
                    dout_d     = mem_rdata;
                    dout_vld_d = 1'b1;
                    mem_waddr  = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q       <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            sp_q       <= sp_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign count    = sp_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed vector table, corner sequences,
// and randomized traffic against a queue-based LIFO reference model.
module tb_stack_unit;
    import stack_pkg::*;

    localparam int W     = STACK_WIDTH;
    localparam int DEPTH = STACK_DEPTH;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout;
    logic          dout_vld;
    logic [CW-1:0] count;
    logic          empty, full, ovf, udf;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    stack_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .tos      (tos),
        .din      (din),
        .clr_err  (clr_err),
        .dout     (dout),
        .dout_vld (dout_vld),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .udf      (udf)
    );

    // reference model: LIFO as a queue, top at the back
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    logic         m_vld, m_ovf, m_udf;

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic po, input logic t,
                              input logic [W-1:0] d, input logic c);
        m_vld = 1'b0;
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (po) begin
            if (mq.size() == 0) begin
                m_udf = 1'b1;
                if (p) mq.push_back(d);
            end else begin
                m_dout = mq[mq.size()-1];
                m_vld  = 1'b1;
                if (p) mq[mq.size()-1] = d;
                else   void'(mq.pop_back());
            end
        end else if (p) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else                    mq.push_back(d);
        end else if (t) begin
            if (mq.size() == 0) begin
                m_udf = 1'b1;
            end else begin
                m_dout = mq[mq.size()-1];
                m_vld  = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // apply one cycle of strobes, sample 1 time unit after the edge
    task automatic cyc(input logic p, input logic po, input logic t,
                       input logic [W-1:0] d, input logic c);
        push = p; pop = po; tos = t; din = d; clr_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"},  32'(full), 0);
        chk({tag, "_dout"},  32'(dout), 0);
        chk({tag, "_vld"},   32'(dout_vld), 0);
        chk({tag, "_ovf"},   32'(ovf), 0);
        chk({tag, "_udf"},   32'(udf), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic         p, po, t, c;
        logic [W-1:0] d;
        logic [W-1:0] e_dout;
        logic         e_vld;
        int           e_cnt;
        logic         e_ovf, e_udf;
    } vec_t;

    vec_t tbl[20];

    initial begin
        // push, pop, tos, clr, din  | dout, vld, count, ovf, udf
        tbl[0]  = '{1, 0, 0, 0, 8'h11, 8'h00, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 8'h22, 8'h00, 0, 2, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 8'h33, 8'h00, 0, 3, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 8'h00, 8'h33, 1, 3, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 8'h00, 8'h33, 1, 2, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 8'h00, 8'h22, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 8'h00, 8'h11, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 8'h00, 8'h11, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 8'h05, 8'h11, 0, 1, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 8'h07, 8'h11, 0, 2, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 8'h09, 8'h07, 1, 2, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 8'h00, 8'h09, 1, 2, 0, 0};
        tbl[12] = '{0, 1, 1, 0, 8'h00, 8'h09, 1, 1, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 8'h00, 8'h05, 1, 0, 0, 0};
        tbl[14] = '{0, 1, 0, 0, 8'h00, 8'h05, 0, 0, 0, 1};
        tbl[15] = '{0, 0, 0, 1, 8'h00, 8'h05, 0, 0, 0, 0};
        tbl[16] = '{0, 1, 0, 1, 8'h00, 8'h05, 0, 0, 0, 1};
        tbl[17] = '{0, 0, 0, 1, 8'h00, 8'h05, 0, 0, 0, 0};
        tbl[18] = '{1, 1, 0, 0, 8'h5A, 8'h05, 0, 1, 0, 1};
        tbl[19] = '{0, 0, 1, 1, 8'h00, 8'h5A, 1, 1, 0, 0};

        // reset state
        #3;
        check_reset_state("rst");
        do_reset();

        // directed vector table
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].p, tbl[i].po, tbl[i].t, tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d_dout", i),  32'(dout), 32'(tbl[i].e_dout));
            chk($sformatf("vec%0d_vld", i),   32'(dout_vld), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].e_cnt == 0));
            chk($sformatf("vec%0d_ovf", i),   32'(ovf), 32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d_udf", i),   32'(udf), 32'(tbl[i].e_udf));
        end

        // overflow: fill, push once more, then pop returns last legal value
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, W'((i + 1) * 3), 0);
        chk("fill_full",  32'(full), 1);
        chk("fill_count", 32'(count), DEPTH);
        chk("fill_ovf",   32'(ovf), 0);
        cyc(1, 0, 0, 8'hAA, 0);
        chk("ovf_full",  32'(full), 1);
        chk("ovf_count", 32'(count), DEPTH);
        chk("ovf_flag",  32'(ovf), 1);
        cyc(0, 1, 0, 8'h00, 0);
        chk("ovf_pop_dout",  32'(dout), (DEPTH * 3) & 8'hFF);
        chk("ovf_pop_count", 32'(count), DEPTH - 1);
        cyc(1, 0, 0, 8'h66, 0);
        cyc(1, 1, 0, 8'h99, 0);
        chk("repl_full_dout",  32'(dout), 8'h66);
        chk("repl_full_count", 32'(count), DEPTH);
        chk("repl_full_ovf",   32'(ovf), 1);
        cyc(0, 0, 1, 8'h00, 0);
        chk("repl_full_tos", 32'(dout), 8'h99);
        cyc(0, 0, 0, 8'h00, 1);
        chk("ovf_clr", 32'(ovf), 0);

        // asynchronous reset between edges with count=4 and a valid read pending
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, W'(8'hC0 + i), 0);
        cyc(0, 0, 1, 8'h00, 0);
        chk("pre_arst_dout",  32'(dout), 8'hC3);
        chk("pre_arst_count", 32'(count), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        #3;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        cyc(1, 0, 0, 8'h42, 0);
        cyc(0, 0, 1, 8'h00, 0);
        chk("post_arst_dout",  32'(dout), 8'h42);
        chk("post_arst_vld",   32'(dout_vld), 1);
        chk("post_arst_count", 32'(count), 1);

        // randomized traffic against the reference model
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            int push_pct;
            push_pct = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 25 : 50;
            for (int n = 0; n < 150; n++) begin
                logic p, po, t, c;
                logic [W-1:0] d;
                p  = ($urandom_range(0, 99) < push_pct);
                po = ($urandom_range(0, 99) < 100 - push_pct);
                t  = ($urandom_range(0, 3) == 0);
                c  = ($urandom_range(0, 15) == 0);
                d  = W'($urandom);
                cyc(p, po, t, d, c);
                model_step(p, po, t, d, c);
                chk("rnd_dout",  32'(dout), 32'(m_dout));
                chk("rnd_vld",   32'(dout_vld), 32'(m_vld));
                chk("rnd_count", 32'(count), mq.size());
                chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
                chk("rnd_full",  32'(full), 32'(mq.size() == DEPTH));
                chk("rnd_ovf",   32'(ovf), 32'(m_ovf));
                chk("rnd_udf",   32'(udf), 32'(m_udf));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
